// File: rtl/vga_sync_gen.sv
// Raster timing generator: free-running pixel/line counters plus sync/blank
// outputs delayed to line up with the registered RGB path of the drawers.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixEn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        hSync,
    output logic        vSync,
    output logic        blankN,
    output logic        startOfFrame,
    output logic        endOfLine
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_ON  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_OFF = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_ON  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_OFF = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] h_cnt_r;
    logic [10:0] v_cnt_r;
    logic        sof_r;
    logic        eol_r;
    logic        h_last_s;
    logic        v_last_s;
    logic        hs_raw_s;
    logic        vs_raw_s;
    logic        bl_raw_s;
    logic        hs_dly_s;
    logic        vs_dly_s;
    logic        bl_dly_s;

    assign h_last_s = (h_cnt_r == H_LAST);
    assign v_last_s = (v_cnt_r == V_LAST);

    // Pixel/line counters and the wrap pulses; pulses only fire on enabled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_r <= 11'd0;
            v_cnt_r <= 11'd0;
            sof_r   <= 1'b0;
            eol_r   <= 1'b0;
        end else if (pixEn) begin
            eol_r <= h_last_s;
            sof_r <= h_last_s & v_last_s;
            if (h_last_s) begin
                h_cnt_r <= 11'd0;
                v_cnt_r <= v_last_s ? 11'd0 : (v_cnt_r + 11'd1);
            end else begin
                h_cnt_r <= h_cnt_r + 11'd1;
                v_cnt_r <= v_cnt_r;
            end
        end else begin
            sof_r <= 1'b0;
            eol_r <= 1'b0;
        end
    end

    assign hs_raw_s = (h_cnt_r >= H_SYNC_ON) && (h_cnt_r < H_SYNC_OFF);
    assign vs_raw_s = (v_cnt_r >= V_SYNC_ON) && (v_cnt_r < V_SYNC_OFF);
    assign bl_raw_s = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);

    generate
        if (PIPE_DLY == 0) begin : g_no_dly
            // Without a delay line, reset still forces the idle output levels
            assign hs_dly_s = hs_raw_s & ~reset;
            assign vs_dly_s = vs_raw_s & ~reset;
            assign bl_dly_s = bl_raw_s & ~reset;
        end else begin : g_dly
            logic [PIPE_DLY-1:0] hs_pipe_r;
            logic [PIPE_DLY-1:0] vs_pipe_r;
            logic [PIPE_DLY-1:0] bl_pipe_r;

            // Delay line runs every clk so it tracks the drawers' RGB register latency
            always_ff @(posedge clk) begin
                if (reset) begin
                    hs_pipe_r <= '0;
                    vs_pipe_r <= '0;
                    bl_pipe_r <= '0;
                end else begin
                    hs_pipe_r[0] <= hs_raw_s;
                    vs_pipe_r[0] <= vs_raw_s;
                    bl_pipe_r[0] <= bl_raw_s;
                    for (int i = 1; i < PIPE_DLY; i++) begin
                        hs_pipe_r[i] <= hs_pipe_r[i-1];
                        vs_pipe_r[i] <= vs_pipe_r[i-1];
                        bl_pipe_r[i] <= bl_pipe_r[i-1];
                    end
                end
            end

            assign hs_dly_s = hs_pipe_r[PIPE_DLY-1];
            assign vs_dly_s = vs_pipe_r[PIPE_DLY-1];
            assign bl_dly_s = bl_pipe_r[PIPE_DLY-1];
        end
    endgenerate

    assign pixelX       = h_cnt_r;
    assign pixelY       = v_cnt_r;
    assign hSync        = SYNC_POL ? hs_dly_s : ~hs_dly_s;
    assign vSync        = SYNC_POL ? vs_dly_s : ~vs_dly_s;
    assign blankN       = bl_dly_s;
    assign startOfFrame = sof_r;
    assign endOfLine    = eol_r;

endmodule
